// File: rtl/axil_order_sequencer.sv
`timescale 1ns/1ps
// AXI4-Lite master that replays (addr, data) orders into a control-register slave, polling a
// status register before each write to the gated order-push address; one transaction in flight.
module axil_order_sequencer #(
    parameter int                         AXIL_DATA_WIDTH = 32,
    parameter int                         AXIL_ADDR_WIDTH = 8,
    parameter logic [AXIL_ADDR_WIDTH-1:0] GATE_ADDR       = 'h48,
    parameter logic [AXIL_ADDR_WIDTH-1:0] STATUS_ADDR     = 'h4c,
    parameter int                         POLL_GAP        = 4,
    parameter int                         CNT_WIDTH       = 16
) (
    input  logic                         m00_axi_aclk,
    input  logic                         m00_axi_aresetn,
    input  logic                         start,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   instr_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   instr_data,
    input  logic                         instr_last,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [CNT_WIDTH-1:0]         sent_count,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                   m00_axi_awprot,
    output logic                         m00_axi_awvalid,
    input  logic                         m00_axi_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                         m00_axi_wvalid,
    input  logic                         m00_axi_wready,
    input  logic [1:0]                   m00_axi_bresp,
    input  logic                         m00_axi_bvalid,
    output logic                         m00_axi_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                   m00_axi_arprot,
    output logic                         m00_axi_arvalid,
    input  logic                         m00_axi_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                   m00_axi_rresp,
    input  logic                         m00_axi_rvalid,
    output logic                         m00_axi_rready
);

    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_POLL_AR, S_POLL_R, S_POLL_WAIT, S_WR, S_WAIT_B, S_DONE, S_ERR
    } state_t;

    state_t                       state_q, state_d;
    logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXIL_DATA_WIDTH-1:0]   data_q, data_d;
    logic                         last_q, last_d;
    logic                         aw_done_q, aw_done_d;
    logic                         w_done_q, w_done_d;
    logic [GW-1:0]                gap_q, gap_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

    logic instr_hs, aw_hs, w_hs, ar_hs, r_hs, b_hs, aw_c, w_c;

    assign instr_hs = instr_valid & instr_ready;
    assign aw_hs    = m00_axi_awvalid & m00_axi_awready;
    assign w_hs     = m00_axi_wvalid & m00_axi_wready;
    assign ar_hs    = m00_axi_arvalid & m00_axi_arready;
    assign r_hs     = m00_axi_rvalid & m00_axi_rready;
    assign b_hs     = m00_axi_bvalid & m00_axi_bready;
    assign aw_c     = aw_done_q | aw_hs;
    assign w_c      = w_done_q | w_hs;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            gap_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        gap_d     = gap_q;
        done_d    = done_q;
        error_d   = error_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (instr_hs) begin
                    addr_d  = instr_addr;
                    data_d  = instr_data;
                    last_d  = instr_last;
                    state_d = (instr_addr == GATE_ADDR) ? S_POLL_AR : S_WR;
                end
            end
            S_POLL_AR: begin
                if (ar_hs) state_d = S_POLL_R;
            end
            S_POLL_R: begin
                if (r_hs) begin
                    if (m00_axi_rresp != 2'b00) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (m00_axi_rdata != '0) begin
                        state_d = S_WR;
                    end else if (POLL_GAP == 0) begin
                        state_d = S_POLL_AR;
                    end else begin
                        state_d = S_POLL_WAIT;
                        gap_d   = GW'(POLL_GAP);
                    end
                end
            end
            S_POLL_WAIT: begin
                // Loaded with POLL_GAP, so exactly POLL_GAP idle cycles sit between polls.
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) state_d = S_POLL_AR;
            end
            S_WR: begin
                if (aw_c && w_c) begin
                    state_d   = S_WAIT_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_c;
                    w_done_d  = w_c;
                end
            end
            S_WAIT_B: begin
                if (b_hs) begin
                    if (m00_axi_bresp != 2'b00) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                        if (last_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready     = (state_q == S_FETCH);
        busy            = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
        done            = done_q;
        error           = error_q;
        sent_count      = cnt_q;
        m00_axi_awaddr  = addr_q;
        m00_axi_awprot  = 3'b000;
        m00_axi_awvalid = (state_q == S_WR) && !aw_done_q;
        m00_axi_wdata   = data_q;
        m00_axi_wstrb   = '1;
        m00_axi_wvalid  = (state_q == S_WR) && !w_done_q;
        m00_axi_bready  = (state_q == S_WAIT_B);
        m00_axi_araddr  = (state_q == S_POLL_AR) ? STATUS_ADDR : '0;
        m00_axi_arprot  = 3'b000;
        m00_axi_arvalid = (state_q == S_POLL_AR);
        m00_axi_rready  = (state_q == S_POLL_R);
    end

endmodule

// File: tb/tb_axil_order_sequencer.sv
`timescale 1ns/1ps
// Directed bench: single-order table plus multi-order, error and mid-run reset sequences
// against a reactive AXI4-Lite slave with configurable per-channel delays.
module tb_axil_order_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0, instr_ready, instr_last = 1'b0;
    logic [7:0]  instr_addr = '0;
    logic [31:0] instr_data = '0;
    logic        busy, done, error;
    logic [15:0] sent_count;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;

    axil_order_sequencer dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n), .start(start),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_addr(instr_addr),
        .instr_data(instr_data), .instr_last(instr_last), .busy(busy), .done(done),
        .error(error), .sent_count(sent_count),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    // Slave configuration and observation logs
    int aw_dly = 0, w_dly = 0, b_dly = 0, zeros_left = 0, err_at = 0;
    logic [7:0]  aw_log[$];
    logic [31:0] w_log[$];
    int ar_cyc[$];
    int ar_n = 0, b_n = 0, wr_n = 0, viol = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit aw_got, w_got, b_pend, b_hs, r_pend, r_hs;
    bit prev_awv, prev_awr, prev_wv, prev_wr;

    // Readies/valids are set on the falling edge; a pair seen high here handshakes at the next rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
            prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
        end else begin
            if (prev_awv && !prev_awr && !awvalid) viol++;
            if (prev_wv && !prev_wr && !wvalid) viol++;
            if (b_hs) begin
                bvalid = 0; b_hs = 0; b_n++;
            end else if (bvalid) begin
                b_hs = bready;
            end else if (b_pend) begin
                if (b_cnt < b_dly) b_cnt++;
                else begin
                    bvalid = 1; b_pend = 0; wr_n++;
                    bresp = (wr_n == err_at) ? 2'b10 : 2'b00;
                    b_hs = bready;
                end
            end
            if (r_hs) begin
                rvalid = 0; r_hs = 0;
            end else if (rvalid) begin
                r_hs = rready;
            end else if (r_pend) begin
                rvalid = 1; r_pend = 0; rresp = 2'b00;
                rdata = (zeros_left > 0) ? 32'd0 : 32'd1;
                if (zeros_left > 0) zeros_left--;
                r_hs = rready;
            end
            arready = 0;
            if (arvalid) begin
                arready = 1; ar_n++; ar_cyc.push_back(cyc); r_pend = 1;
                if (araddr != 8'h4c) viol++;
            end
            awready = 0;
            if (awvalid) begin
                if (aw_cnt < aw_dly) aw_cnt++;
                else begin
                    awready = 1; aw_cnt = 0; aw_got = 1; aw_log.push_back(awaddr);
                    if (b_pend || bvalid) viol++;
                end
            end else aw_cnt = 0;
            wready = 0;
            if (wvalid) begin
                if (w_cnt < w_dly) w_cnt++;
                else begin
                    wready = 1; w_cnt = 0; w_got = 1; w_log.push_back(wdata);
                    if (wstrb != 4'hf) viol++;
                end
            end else w_cnt = 0;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            prev_awv = awvalid; prev_awr = awready; prev_wv = wvalid; prev_wr = wready;
        end
    end

    // Order source
    logic [7:0]  o_addr[8];
    logic [31:0] o_data[8];
    logic        o_last[8];
    int f_n = 0, f_idx = 0, f_gap = 0, f_gapcfg = 0;
    bit f_hs;

    always @(negedge clk) begin
        if (!rst_n) begin
            instr_valid = 0; f_idx = 0; f_gap = 0; f_hs = 0;
        end else begin
            if (f_hs) begin
                f_idx++; f_hs = 0; f_gap = 0; instr_valid = 0;
            end
            if (f_idx < f_n) begin
                if (!instr_valid && f_gap < f_gapcfg) f_gap++;
                else begin
                    instr_valid = 1;
                    instr_addr = o_addr[f_idx]; instr_data = o_data[f_idx]; instr_last = o_last[f_idx];
                    f_hs = instr_ready;
                end
            end else instr_valid = 0;
        end
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          awd, wd, bd, zeros;
        logic [1:0]  bresp;
        logic        exp_done, exp_err;
        int          exp_cnt, exp_ar;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        aw_log.delete(); w_log.delete(); ar_cyc.delete();
        ar_n = 0; b_n = 0; wr_n = 0; viol = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_end(input int lim);
        int k = 0;
        while (!(done || error) && k < lim) begin
            @(negedge clk); k++;
        end
        check("run_completes", k < lim, 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check(nm, {awvalid, wvalid, arvalid, rready, bready, instr_ready, busy, done, error}, 0);
        check({nm, "_cnt"}, sent_count, 0);
        check({nm, "_addr"}, {awaddr, araddr, wdata}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h10, 32'hDEADBEEF, 0, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1, 0};
        tbl[1] = '{8'h48, 32'h00000005, 0, 0, 0, 2, 2'b00, 1'b1, 1'b0, 1, 3};
        tbl[2] = '{8'h20, 32'h0000A5A5, 2, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1, 0};
        tbl[3] = '{8'h24, 32'h00001234, 0, 3, 0, 0, 2'b00, 1'b1, 1'b0, 1, 0};
        tbl[4] = '{8'h30, 32'h0BADF00D, 0, 0, 2, 0, 2'b10, 1'b0, 1'b1, 0, 0};
        tbl[5] = '{8'h48, 32'h00000077, 0, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1, 1};
        tbl[6] = '{8'h14, 32'h55AA55AA, 1, 1, 3, 0, 2'b00, 1'b1, 1'b0, 1, 0};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_const", {awprot, arprot, wstrb}, 10'h00f);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");

        for (int i = 0; i < 7; i++) begin
            clr();
            aw_dly = tbl[i].awd; w_dly = tbl[i].wd; b_dly = tbl[i].bd;
            zeros_left = tbl[i].zeros; err_at = (tbl[i].bresp != 2'b00) ? 1 : 0;
            o_addr[0] = tbl[i].addr; o_data[0] = tbl[i].data; o_last[0] = 1'b1;
            f_gapcfg = 0; f_idx = 0; f_n = 1;
            pulse_start();
            wait_end(500);
            check($sformatf("v%0d_done", i), done, tbl[i].exp_done);
            check($sformatf("v%0d_error", i), error, tbl[i].exp_err);
            check($sformatf("v%0d_count", i), sent_count, tbl[i].exp_cnt);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_ar_count", i), ar_n, tbl[i].exp_ar);
            check($sformatf("v%0d_aw_count", i), aw_log.size(), 1);
            check($sformatf("v%0d_b_count", i), b_n, 1);
            if (aw_log.size() == 1 && w_log.size() == 1) begin
                check($sformatf("v%0d_awaddr", i), aw_log[0], tbl[i].addr);
                check($sformatf("v%0d_wdata", i), w_log[0], tbl[i].data);
            end
            // AR-to-AR spacing covers the AR beat, the R beat and the idle gap of 4
            for (int j = 1; j < ar_cyc.size(); j++)
                check($sformatf("v%0d_poll_gap%0d", i, j), (ar_cyc[j] - ar_cyc[j-1]) >= 6, 1);
            check($sformatf("v%0d_protocol", i), viol, 0);
            check($sformatf("v%0d_idle", i), {busy, instr_ready}, 0);
        end

        // Three-order stream with source gaps and slow B
        begin
            int pc = 0, k = 0;
            clr(); aw_dly = 0; w_dly = 0; b_dly = 5; zeros_left = 0; err_at = 0;
            o_addr[0] = 8'h10; o_data[0] = 32'h11; o_last[0] = 0;
            o_addr[1] = 8'h48; o_data[1] = 32'h22; o_last[1] = 0;
            o_addr[2] = 8'h18; o_data[2] = 32'h33; o_last[2] = 1;
            f_gapcfg = 3; f_idx = 0; f_n = 3;
            pulse_start();
            while (!done && k < 1000) begin
                pc = sent_count; @(negedge clk); k++;
            end
            check("stream_completes", k < 1000, 1);
            check("stream_count_at_done", sent_count, 3);
            check("stream_count_before_done", pc, 2);
            repeat (3) @(negedge clk);
            check("stream_writes", aw_log.size(), 3);
            if (aw_log.size() == 3 && w_log.size() == 3) begin
                check("stream_order", {aw_log[0], aw_log[1], aw_log[2]}, 24'h104818);
                check("stream_data", {w_log[0][7:0], w_log[1][7:0], w_log[2][7:0]}, 24'h112233);
            end
            check("stream_ar", ar_n, 1);
            check("stream_protocol", viol, 0);
        end

        // Error on the second order aborts the run; the next start clears error
        clr(); b_dly = 0; f_gapcfg = 0; err_at = 2;
        o_addr[0] = 8'h10; o_data[0] = 32'h1; o_last[0] = 0;
        o_addr[1] = 8'h14; o_data[1] = 32'h2; o_last[1] = 0;
        o_addr[2] = 8'h18; o_data[2] = 32'h3; o_last[2] = 1;
        f_idx = 0; f_n = 3;
        pulse_start();
        wait_end(500);
        check("err_error", error, 1);
        check("err_done", done, 0);
        check("err_count", sent_count, 1);
        repeat (5) @(negedge clk);
        check("err_no_fetch", {instr_valid, instr_ready}, 2'b10);
        check("err_writes", aw_log.size(), 2);
        f_n = 0; clr(); err_at = 0;
        o_addr[0] = 8'h10; o_data[0] = 32'h7; o_last[0] = 1;
        f_idx = 0; f_n = 1;
        pulse_start();
        check("restart_clears", {error, done, busy}, 3'b001);
        wait_end(500);
        check("restart_done", {done, error, sent_count}, {2'b10, 16'd1});

        // Reset during POLL_WAIT
        begin
            int k = 0;
            repeat (2) @(negedge clk);
            clr(); zeros_left = 1000;
            o_addr[0] = 8'h48; o_data[0] = 32'h9; o_last[0] = 1;
            f_idx = 0; f_n = 1;
            pulse_start();
            while (ar_n < 1 && k < 200) begin
                @(negedge clk); k++;
            end
            check("pw_reached", k < 200, 1);
            repeat (3) @(negedge clk);
            check("pw_state", {busy, arvalid, rready}, 3'b100);
            #2 rst_n = 0;
            #1 check_idle_outputs("pw_async_reset");
            @(negedge clk); f_n = 0;
            #1 rst_n = 1;
            repeat (3) @(negedge clk);
            check_idle_outputs("pw_after_release");
        end

        // Reset during WR
        begin
            int k = 0;
            clr(); zeros_left = 0; aw_dly = 20; w_dly = 20;
            o_addr[0] = 8'h30; o_data[0] = 32'hCAFE; o_last[0] = 1;
            f_idx = 0; f_n = 1;
            pulse_start();
            while (!awvalid && k < 200) begin
                @(negedge clk); k++;
            end
            check("wr_reached", {awvalid, wvalid, awaddr, wdata}, {2'b11, 8'h30, 32'hCAFE});
            #2 rst_n = 0;
            #1 check_idle_outputs("wr_async_reset");
            @(negedge clk); f_n = 0;
            #1 rst_n = 1;
            repeat (3) @(negedge clk);
            check_idle_outputs("wr_after_release");
            clr(); aw_dly = 0; w_dly = 0;
            o_addr[0] = 8'h1c; o_data[0] = 32'h5; o_last[0] = 1;
            f_idx = 0; f_n = 1;
            pulse_start();
            wait_end(500);
            check("post_reset_run", {done, error, sent_count}, {2'b10, 16'd1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_order_sequencer.md
Name: axil_order_sequencer

Overview:
Synthesizable AXI4-Lite master that replays a stream of (address, data) accelerator orders into the accelerator's control-register slave. It replaces bench-driven order injection so an on-chip loader (FIFO/DMA) can drive the accelerator directly. Before any write to the gated order-push register, it polls a status register until that register reads non-zero. Errors are detected, and progress is counted.

Parameters:
AXIL_DATA_WIDTH, 32, AXI-Lite data width
AXIL_ADDR_WIDTH, 8, AXI-Lite address width
GATE_ADDR, 8'h48, order-push address; writes here require the status check
STATUS_ADDR, 8'h4c, status register polled before a GATE_ADDR write; non-zero means ready
POLL_GAP, 4, idle cycles between consecutive status polls (≥0)
CNT_WIDTH, 16, width of sent_count

Ports:
m00_axi_aclk  in  1  clock
m00_axi_aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
instr_valid  in  1  order available
instr_ready  out  1  order accepted when valid&ready
instr_addr  in  AXIL_ADDR_WIDTH  order register address
instr_data  in  AXIL_DATA_WIDTH  order write data
instr_last  in  1  marks final order of the run
busy  out  1  run in progress
done  out  1  run completed cleanly; held until next start
error  out  1  sticky; nonzero BRESP/RRESP seen; held until next start
sent_count  out  CNT_WIDTH  writes completed this run
m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master signals at the stated widths

Behaviour:
- Reset: state IDLE; every valid/ready output, busy, done, error and instr_ready = 0; sent_count = 0. All address and data outputs = 0. awprot and arprot are constant 3'b000. wstrb is constant all-ones.
- IDLE: start=1 → FETCH. Clear done, error and sent_count; set busy. start is ignored in all other states.
- FETCH: instr_ready=1. On handshake, latch addr, data and last, and drop instr_ready the next cycle. If addr==GATE_ADDR → POLL_AR, else → WR.
- POLL_AR: arvalid=1, araddr=STATUS_ADDR. Hold until arready → POLL_R.
- POLL_R: rready=1. On rvalid:
  - rresp≠0 → ERR.
  - rdata≠0 → WR.
  - rdata==0 → POLL_WAIT. Counter is loaded with POLL_GAP; if POLL_GAP=0, go directly to POLL_AR.
- POLL_WAIT: count down to 0 → POLL_AR. Polling is unbounded; there is no timeout.
- WR: awvalid and wvalid both rise in the same cycle with the latched addr and data. Each valid drops independently on its own handshake. AW and W may complete in either order or in the same cycle. Once both have completed → WAIT_B. Valids never drop before their handshake.
- WAIT_B: bready=1. On bvalid:
  - bresp≠0 → ERR.
  - Otherwise sent_count+1 (saturating at all-ones). Then if last → DONE, else → FETCH.
- DONE: done=1, busy=0 → IDLE. done stays high in IDLE until the next start.
- ERR: error=1, busy=0 → IDLE. The run aborts and no further orders are fetched.
- Minimum latency for one ungated order: 1 fetch cycle, ≥1 AW/W cycle, ≥1 B cycle.
- Reset asserted mid-transaction forces reset values immediately. Any outstanding AXI transaction is abandoned.

Test Plan:
- Ungated order (0x10, 0xDEADBEEF, last) with slave readies tied high → exactly one AW/W with those values, sent_count=1, done=1, no AR issued.
- Gated order (0x48, 0x5) with status reads 0, 0, 1 and POLL_GAP=4 → three ARs to 0x4C spaced ≥4 idle cycles apart, then one write to 0x48; sent_count=1.
- Slave accepts W two cycles before AW, and in another run AW before W → wvalid/awvalid each drop only after their own handshake; a single B is accepted.
- Three-order stream with instr_valid gaps and bvalid delayed 5 cycles → writes occur in order, at most one transaction is outstanding, and sent_count reaches 3 exactly when done rises.
- Second order returns bresp=2'b10 → error=1, done=0, sent_count=1, instr_ready stays 0; the next start clears error.
- aresetn pulsed low during POLL_WAIT and during WR → all outputs return to reset values asynchronously, and the state is IDLE after release.
